// File: rtl/clk3_handshake_rx.sv
// Receiving end of a four-phase req/ack handshake into the clk3 domain.
// Synchronises src_req, captures src_data and offers it to the sink over valid/ready.
module clk3_handshake_rx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk3,
    input  logic              rst_n,
    input  logic              src_req,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ack,
    output logic              dst_valid,
    output logic [DATA_W-1:0] dst_data,
    input  logic              dst_ready,
    output logic              busy,
    output logic              proto_err
);

    typedef enum logic [1:0] {StIdle, StValid, StAck} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   src_ack_q, src_ack_d;
    logic                   dst_valid_q, dst_valid_d;
    logic [DATA_W-1:0]      dst_data_q, dst_data_d;
    logic                   proto_err_q, proto_err_d;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk3) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= StIdle;
            src_ack_q   <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], src_req};
            state_q     <= state_d;
            src_ack_q   <= src_ack_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_ack_d   = src_ack_q;
        dst_valid_d = dst_valid_q;
        dst_data_d  = dst_data_q;
        proto_err_d = proto_err_q;
        case (state_q)
            StIdle: begin
                if (req_s) begin
                    dst_data_d  = src_data;
                    dst_valid_d = 1'b1;
                    state_d     = StValid;
                end
            end
            StValid: begin
                // Sender dropped req before seeing ack; still finish the word.
                if (!req_s) begin
                    proto_err_d = 1'b1;
                end
                if (dst_ready) begin
                    dst_valid_d = 1'b0;
                    src_ack_d   = 1'b1;
                    state_d     = StAck;
                end
            end
            StAck: begin
                if (!req_s) begin
                    src_ack_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign src_ack   = src_ack_q;
    assign dst_valid = dst_valid_q;
    assign dst_data  = dst_data_q;
    assign proto_err = proto_err_q;
    assign busy      = (state_q != StIdle);

endmodule
